// File: rtl/acumulador_multicanal.sv
// acumulador_multicanal: time-multiplexed, per-channel accumulator of signed
// partial products. Each accepted term is added to its channel's running sum.
// The sample completes on `listo`, or is forced when the term limit is reached,
// and the result is published on f_y with a one-cycle f_y_valid pulse.
// Optional feature macro: ACUMULADOR_SAT_EN (output saturation and `sat` flag).
// Without it, results wrap to WIDTH bits and `sat` is tied low.
module acumulador_multicanal #(
    parameter int WIDTH     = 25,
    parameter int CHANNELS  = 2,
    parameter int GUARD     = 4,
    parameter int MAX_TERMS = 16,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [CW-1:0]    canal,
    input  logic             listo,
    output logic [WIDTH-1:0] rec,
    output logic [WIDTH-1:0] f_y,
    output logic             f_y_valid,
    output logic [CW-1:0]    f_y_canal,
    output logic             sat,
    output logic             err
);

    localparam int AW  = WIDTH + GUARD;
    localparam int NW  = $clog2(MAX_TERMS + 1);
    localparam int CWP = CW + 1;
    localparam logic [NW-1:0]  CNT_LAST = NW'(MAX_TERMS - 1);
    localparam logic [CWP-1:0] CH_LIM   = CWP'(CHANNELS);

    // The guard bits must cover the worst-case growth of MAX_TERMS full-scale
    // terms, otherwise the internal sum itself could overflow.
    generate
        if (MAX_TERMS > (2 ** GUARD)) begin : g_bad_max_terms
            $error("acumulador_multicanal: MAX_TERMS must not exceed 2**GUARD");
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("acumulador_multicanal: CHANNELS must be at least 1");
        end
        if (MAX_TERMS < 1) begin : g_bad_terms_min
            $error("acumulador_multicanal: MAX_TERMS must be at least 1");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } ch_state_e;

    // Per-channel state
    ch_state_e         st_q  [CHANNELS];
    ch_state_e         st_d  [CHANNELS];
    logic [AW-1:0]     acc_q [CHANNELS];
    logic [AW-1:0]     acc_d [CHANNELS];
    logic [NW-1:0]     cnt_q [CHANNELS];
    logic [NW-1:0]     cnt_d [CHANNELS];

    // Output registers
    logic [WIDTH-1:0]  rec_q,       rec_d;
    logic [WIDTH-1:0]  f_y_q,       f_y_d;
    logic              f_y_valid_q, f_y_valid_d;
    logic [CW-1:0]     f_y_canal_q, f_y_canal_d;
    logic              err_q,       err_d;

    // Datapath for the addressed channel
    ch_state_e         sel_st_s;
    logic [AW-1:0]     sel_acc_s;
    logic [NW-1:0]     sel_cnt_s;
    logic [AW-1:0]     acc_base_s;
    logic [AW-1:0]     sum_s;
    logic              ch_ok_s;
    logic              forced_s;
    logic              done_s;
    logic [WIDTH-1:0]  fmt_s;

`ifdef ACUMULADOR_SAT_EN
    logic              sat_q, sat_d;
    logic              clip_s;

    // True when the wide sum does not fit in WIDTH signed bits.
    function automatic logic sum_clips(input logic [AW-1:0] s);
        logic [GUARD:0] top;
        logic           res;
        top = s[AW-1:WIDTH-1];
        if ((&top) || (~|top)) begin
            res = 1'b0;
        end else begin
            res = 1'b1;
        end
        return res;
    endfunction

    // Clamp the wide sum to the WIDTH-bit signed range.
    function automatic logic [WIDTH-1:0] sum_fmt(input logic [AW-1:0] s);
        logic [WIDTH-1:0] res;
        if (!sum_clips(s)) begin
            res = s[WIDTH-1:0];
        end else if (s[AW-1]) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return res;
    endfunction
`endif

    // Pick out the addressed channel, form the new sum and its output format.
    always_comb begin
        sel_st_s  = ST_EMPTY;
        sel_acc_s = {AW{1'b0}};
        sel_cnt_s = {NW{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (canal == CW'(c)) begin
                sel_st_s  = st_q[c];
                sel_acc_s = acc_q[c];
                sel_cnt_s = cnt_q[c];
            end else begin
                sel_st_s  = sel_st_s;
            end
        end
        ch_ok_s = ({1'b0, canal} < CH_LIM);
        // An EMPTY channel starts from zero regardless of stored contents.
        if (sel_st_s == ST_ACCUM) begin
            acc_base_s = sel_acc_s;
        end else begin
            acc_base_s = {AW{1'b0}};
        end
        sum_s    = acc_base_s + {{GUARD{in[WIDTH-1]}}, in};
        forced_s = (sel_cnt_s == CNT_LAST);
        done_s   = listo | forced_s;
`ifdef ACUMULADOR_SAT_EN
        fmt_s  = sum_fmt(sum_s);
        clip_s = sum_clips(sum_s);
`else
        fmt_s  = sum_s[WIDTH-1:0];
`endif
    end

    // Next-state for channel state and outputs; only the addressed channel moves.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            st_d[c]  = st_q[c];
            acc_d[c] = acc_q[c];
            cnt_d[c] = cnt_q[c];
        end
        rec_d       = rec_q;
        f_y_d       = f_y_q;
        f_y_canal_d = f_y_canal_q;
        f_y_valid_d = 1'b0;
        err_d       = 1'b0;
`ifdef ACUMULADOR_SAT_EN
        sat_d       = sat_q;
`endif
        if (in_valid) begin
            if (ch_ok_s) begin
                rec_d = fmt_s;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (canal == CW'(c)) begin
                        if (done_s) begin
                            st_d[c]  = ST_EMPTY;
                            acc_d[c] = {AW{1'b0}};
                            cnt_d[c] = {NW{1'b0}};
                        end else begin
                            st_d[c]  = ST_ACCUM;
                            acc_d[c] = sum_s;
                            cnt_d[c] = sel_cnt_s + {{(NW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        st_d[c] = st_d[c];
                    end
                end
                if (done_s) begin
                    f_y_d       = fmt_s;
                    f_y_canal_d = canal;
                    f_y_valid_d = 1'b1;
                    // A limit hit without listo means the sample was cut short.
                    err_d       = forced_s & ~listo;
`ifdef ACUMULADOR_SAT_EN
                    sat_d       = clip_s;
`endif
                end else begin
                    f_y_valid_d = 1'b0;
                end
            end else begin
                // Out-of-range channel: drop the term and flag it.
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // Register channel state and outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]  <= ST_EMPTY;
                acc_q[c] <= {AW{1'b0}};
                cnt_q[c] <= {NW{1'b0}};
            end
            rec_q       <= {WIDTH{1'b0}};
            f_y_q       <= {WIDTH{1'b0}};
            f_y_canal_q <= {CW{1'b0}};
            f_y_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]  <= st_d[c];
                acc_q[c] <= acc_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            rec_q       <= rec_d;
            f_y_q       <= f_y_d;
            f_y_canal_q <= f_y_canal_d;
            f_y_valid_q <= f_y_valid_d;
            err_q       <= err_d;
        end
    end

`ifdef ACUMULADOR_SAT_EN
    // Saturation flag travels and holds with f_y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

    assign rec       = rec_q;
    assign f_y       = f_y_q;
    assign f_y_valid = f_y_valid_q;
    assign f_y_canal = f_y_canal_q;
    assign err       = err_q;

endmodule

// File: tb/tb_acumulador_multicanal.sv
// Directed testbench for acumulador_multicanal with hand-computed expectations.
// A second instance with three channels exercises the out-of-range channel.
module tb_acumulador_multicanal;

    localparam int W = 25;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  term_in;
    logic          canal;
    logic          listo;
    logic [W-1:0]  rec;
    logic [W-1:0]  f_y;
    logic          f_y_valid;
    logic          f_y_canal;
    logic          sat;
    logic          err;

    logic          in_valid3;
    logic [1:0]    canal3;
    logic [W-1:0]  rec3;
    logic [W-1:0]  f_y3;
    logic          f_y_valid3;
    logic [1:0]    f_y_canal3;
    logic          sat3;
    logic          err3;

    int errors = 0;
    int checks = 0;

    acumulador_multicanal u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (term_in),
        .canal     (canal),
        .listo     (listo),
        .rec       (rec),
        .f_y       (f_y),
        .f_y_valid (f_y_valid),
        .f_y_canal (f_y_canal),
        .sat       (sat),
        .err       (err)
    );

    acumulador_multicanal #(.CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in        (term_in),
        .canal     (canal3),
        .listo     (listo),
        .rec       (rec3),
        .f_y       (f_y3),
        .f_y_valid (f_y_valid3),
        .f_y_canal (f_y_canal3),
        .sat       (sat3),
        .err       (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One term to the 2-channel DUT; returns 1 time unit after the capturing edge.
    task automatic term(input logic ch, input logic [W-1:0] v, input logic l);
        in_valid = 1'b1;
        canal    = ch;
        term_in  = v;
        listo    = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        listo    = 1'b0;
    endtask

    // One term to the 3-channel DUT.
    task automatic term3(input logic [1:0] ch, input logic [W-1:0] v, input logic l);
        in_valid3 = 1'b1;
        canal3    = ch;
        term_in   = v;
        listo     = l;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        listo     = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        term_in   = '0;
        canal     = 1'b0;
        canal3    = 2'd0;
        listo     = 1'b0;
        repeat (2) idle();

        // Reset state
        chk("rst_rec",       32'(rec),       32'h0);
        chk("rst_f_y",       32'(f_y),       32'h0);
        chk("rst_f_y_valid", 32'(f_y_valid), 32'h0);
        chk("rst_f_y_canal", 32'(f_y_canal), 32'h0);
        chk("rst_sat",       32'(sat),       32'h0);
        chk("rst_err",       32'(err),       32'h0);
        rst = 1'b1;
        idle();

        // Reset mid-sample: partial sum on ch0 is discarded
        term(1'b0, 25'h0000010, 1'b0);
        term(1'b0, 25'h0000020, 1'b0);
        chk("mid_rec_before", 32'(rec), 32'h30);
        #2 rst = 1'b0;
        #1;
        chk("mid_rec_async",   32'(rec),       32'h0);
        chk("mid_f_y_async",   32'(f_y),       32'h0);
        chk("mid_fyv_async",   32'(f_y_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        term(1'b0, 25'h0000005, 1'b1);
        chk("mid_f_y_after", 32'(f_y),       32'h5);
        chk("mid_fyv_after", 32'(f_y_valid), 32'h1);

        // Single channel
        term(1'b0, 25'h0000010, 1'b0);
        chk("sc_rec1", 32'(rec),       32'h10);
        chk("sc_fyv1", 32'(f_y_valid), 32'h0);
        term(1'b0, 25'h0000020, 1'b0);
        chk("sc_rec2", 32'(rec), 32'h30);
        term(1'b0, 25'h0000030, 1'b1);
        chk("sc_rec3",   32'(rec),       32'h60);
        chk("sc_f_y",    32'(f_y),       32'h60);
        chk("sc_fyv3",   32'(f_y_valid), 32'h1);
        chk("sc_canal",  32'(f_y_canal), 32'h0);
        chk("sc_err",    32'(err),       32'h0);
        // listo without in_valid is ignored
        listo = 1'b1;
        idle();
        listo = 1'b0;
        chk("sc_fyv_pulse", 32'(f_y_valid), 32'h0);
        chk("sc_f_y_held",  32'(f_y),       32'h60);
        chk("sc_rec_held",  32'(rec),       32'h60);

        // Interleave two channels, back-to-back completions
        term(1'b0, 25'h0000005, 1'b0);
        term(1'b1, 25'h1FFFFFD, 1'b0);
        chk("il_rec_ch1", 32'(rec), 32'h1FFFFFD);
        term(1'b0, 25'h0000007, 1'b1);
        chk("il_f_y0",   32'(f_y),       32'h000000C);
        chk("il_canal0", 32'(f_y_canal), 32'h0);
        chk("il_fyv0",   32'(f_y_valid), 32'h1);
        term(1'b1, 25'h1FFFFFC, 1'b1);
        chk("il_f_y1",   32'(f_y),       32'h1FFFFF9);
        chk("il_canal1", 32'(f_y_canal), 32'h1);
        chk("il_fyv1",   32'(f_y_valid), 32'h1);

        // Positive overflow
        term(1'b0, 25'h0FFFFFF, 1'b0);
        term(1'b0, 25'h0FFFFFF, 1'b1);
`ifdef ACUMULADOR_SAT_EN
        chk("po_f_y", 32'(f_y), 32'h0FFFFFF);
        chk("po_sat", 32'(sat), 32'h1);
`else
        chk("po_f_y", 32'(f_y), 32'h1FFFFFE);
        chk("po_sat", 32'(sat), 32'h0);
`endif

        // Negative overflow
        term(1'b1, 25'h1000000, 1'b0);
        term(1'b1, 25'h1000000, 1'b1);
`ifdef ACUMULADOR_SAT_EN
        chk("no_f_y", 32'(f_y), 32'h1000000);
        chk("no_sat", 32'(sat), 32'h1);
`else
        chk("no_f_y", 32'(f_y), 32'h0000000);
        chk("no_sat", 32'(sat), 32'h0);
`endif
        chk("no_canal", 32'(f_y_canal), 32'h1);

        // Term limit: 16th term without listo is forced
        for (int i = 0; i < 15; i++) begin
            term(1'b1, 25'h0000001, 1'b0);
        end
        chk("tl_rec15", 32'(rec),       32'hF);
        chk("tl_fyv15", 32'(f_y_valid), 32'h0);
        chk("tl_err15", 32'(err),       32'h0);
        term(1'b1, 25'h0000001, 1'b0);
        chk("tl_f_y",   32'(f_y),       32'h10);
        chk("tl_fyv",   32'(f_y_valid), 32'h1);
        chk("tl_err",   32'(err),       32'h1);
        chk("tl_canal", 32'(f_y_canal), 32'h1);
        idle();
        chk("tl_err_pulse", 32'(err), 32'h0);
        term(1'b1, 25'h0000003, 1'b1);
        chk("tl_empty_f_y", 32'(f_y), 32'h3);
        chk("tl_empty_err", 32'(err), 32'h0);

        // Out-of-range channel on the 3-channel instance
        term3(2'd2, 25'h0000009, 1'b0);
        chk("bc_rec_ok", 32'(rec3), 32'h9);
        chk("bc_err_ok", 32'(err3), 32'h0);
        term3(2'd3, 25'h0000100, 1'b1);
        chk("bc_err",   32'(err3),       32'h1);
        chk("bc_rec",   32'(rec3),       32'h9);
        chk("bc_fyv",   32'(f_y_valid3), 32'h0);
        chk("bc_f_y",   32'(f_y3),       32'h0);
        term3(2'd2, 25'h0000001, 1'b1);
        chk("bc_f_y2",   32'(f_y3),       32'hA);
        chk("bc_canal2", 32'(f_y_canal3), 32'h2);
        chk("bc_fyv2",   32'(f_y_valid3), 32'h1);
        chk("bc_err2",   32'(err3),       32'h0);
        chk("bc_sat2",   32'(sat3),       32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
